// File: rtl/crc32_pkg.sv
// Shared constants, FSM state type and the bytewise reflected CRC-32 step
// used by the Ethernet FCS engine.
package crc32_pkg;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  // One byte through the reflected LFSR, LSB first, eight unrolled steps.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_fold.sv
// Combinational fold of one beat into the CRC register: enabled bytes are
// applied in ascending lane order, disabled lanes pass the value through.
module crc32_fold
  import crc32_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int KEEP_W = DATA_W / 8
) (
  input  logic [31:0]       crc_in,
  input  logic [DATA_W-1:0] data,
  input  logic [KEEP_W-1:0] keep,
  output logic [31:0]       crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < KEEP_W; i++) begin
      if (keep[i]) begin
        crc_out = crc32_byte(crc_out, data[8*i +: 8]);
      end
    end
  end

endmodule

// File: rtl/crc32_stream.sv
// Streaming Ethernet CRC-32 engine: framed beats in, one registered FCS /
// check result per frame out over a one-deep valid/ready slot.
module crc32_stream
  import crc32_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int KEEP_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [KEEP_W-1:0] s_keep,
  input  logic              s_sof,
  input  logic              s_eof,
  input  logic              s_mode,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [31:0]       m_crc,
  output logic              m_ok,
  output logic              m_err,
  output logic              busy
);

  state_t      state, state_next;
  logic [31:0] crc_reg, crc_next;
  logic [31:0] fold_seed, fold_out;
  logic        err_flag, err_next;
  logic        mode_reg, mode_next;
  logic        emit, emit_err, emit_mode;
  logic        accept, beat_err, keep_legal_eof;
  logic [KEEP_W-1:0] keep_inc;

  // Only an eof beat needs the result slot, so only it is held back.
  assign s_ready = !(m_valid && !m_ready && s_eof);
  assign accept  = s_valid && s_ready;
  assign busy    = (state == ST_ACCUM);

  // Contiguous-from-bit-0 means keep+1 is a power of two.
  assign keep_inc       = s_keep + 1'b1;
  assign keep_legal_eof = (s_keep != '0) && ((s_keep & keep_inc) == '0);
  assign beat_err       = s_eof ? !keep_legal_eof : !(&s_keep);

  assign fold_seed = s_sof ? CRC_INIT : crc_reg;

  crc32_fold #(.DATA_W(DATA_W)) u_fold (
    .crc_in  (fold_seed),
    .data    (s_data),
    .keep    (s_keep),
    .crc_out (fold_out)
  );

  always_comb begin
    state_next = state;
    crc_next   = crc_reg;
    err_next   = err_flag;
    mode_next  = mode_reg;
    emit       = 1'b0;
    emit_err   = beat_err || err_flag;
    emit_mode  = mode_reg;
    if (accept) begin
      if (s_sof) begin
        mode_next = s_mode;
        emit_mode = s_mode;
        // A sof inside a frame aborts the old frame and taints the new one.
        emit_err  = beat_err || err_flag || (state == ST_ACCUM);
      end
      if (!s_sof && state == ST_IDLE) begin
        err_next = 1'b1;
      end else if (s_eof) begin
        emit       = 1'b1;
        state_next = ST_IDLE;
        crc_next   = CRC_INIT;
        err_next   = 1'b0;
      end else begin
        state_next = ST_ACCUM;
        crc_next   = fold_out;
        err_next   = emit_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      crc_reg  <= CRC_INIT;
      err_flag <= 1'b0;
      mode_reg <= 1'b0;
    end else begin
      state    <= state_next;
      crc_reg  <= crc_next;
      err_flag <= err_next;
      mode_reg <= mode_next;
    end
  end

  // Result slot: a new result may load on the same edge the old one drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_crc   <= 32'h0;
      m_ok    <= 1'b0;
      m_err   <= 1'b0;
    end else if (emit) begin
      m_valid <= 1'b1;
      m_crc   <= ~fold_out;
      m_ok    <= emit_mode && (fold_out == CRC_RESIDUE);
      m_err   <= emit_err;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_crc32_stream.sv
// Directed bench for crc32_stream at DATA_W=32, plus 8 and 64 bit instances.
module tb_crc32_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        s_valid, s_ready, s_sof, s_eof, s_mode;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic        m_valid, m_ready, m_ok, m_err, busy;
  logic [31:0] m_crc;

  logic        s8_valid, s8_ready, s8_sof, s8_eof;
  logic [7:0]  s8_data;
  logic [0:0]  s8_keep;
  logic        m8_valid, m8_ok, m8_err, busy8;
  logic [31:0] m8_crc;

  logic        s64_valid, s64_ready, s64_sof, s64_eof;
  logic [63:0] s64_data;
  logic [7:0]  s64_keep;
  logic        m64_valid, m64_ok, m64_err, busy64;
  logic [31:0] m64_crc;

  int checks = 0;
  int errors = 0;

  crc32_stream #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_keep(s_keep), .s_sof(s_sof), .s_eof(s_eof), .s_mode(s_mode),
    .m_valid(m_valid), .m_ready(m_ready), .m_crc(m_crc), .m_ok(m_ok),
    .m_err(m_err), .busy(busy)
  );

  crc32_stream #(.DATA_W(8)) dut8 (
    .clk(clk), .rst(rst), .s_valid(s8_valid), .s_ready(s8_ready), .s_data(s8_data),
    .s_keep(s8_keep), .s_sof(s8_sof), .s_eof(s8_eof), .s_mode(1'b0),
    .m_valid(m8_valid), .m_ready(1'b1), .m_crc(m8_crc), .m_ok(m8_ok),
    .m_err(m8_err), .busy(busy8)
  );

  crc32_stream #(.DATA_W(64)) dut64 (
    .clk(clk), .rst(rst), .s_valid(s64_valid), .s_ready(s64_ready), .s_data(s64_data),
    .s_keep(s64_keep), .s_sof(s64_sof), .s_eof(s64_eof), .s_mode(1'b0),
    .m_valid(m64_valid), .m_ready(1'b1), .m_crc(m64_crc), .m_ok(m64_ok),
    .m_err(m64_err), .busy(busy64)
  );

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    @(posedge clk); #1;
  endtask

  // Presents one beat, waits (bounded) for s_ready, ends 1 time unit after the accepting edge.
  task automatic beat(input logic [31:0] d, input logic [3:0] k,
                      input logic sof, input logic eof, input logic mode);
    int guard = 0;
    s_valid = 1'b1; s_data = d; s_keep = k; s_sof = sof; s_eof = eof; s_mode = mode;
    #1;
    while (!s_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    if (guard >= 20) begin checks++; errors++; $display("FAIL beat_accept timed out waiting for s_ready"); end
    @(posedge clk); #1;
    s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0;
  endtask

  task automatic beat8(input logic [7:0] d, input logic sof, input logic eof);
    s8_valid = 1'b1; s8_data = d; s8_keep = 1'b1; s8_sof = sof; s8_eof = eof;
    #1;
    checks++; if (s8_ready !== 1'b1) begin errors++; $display("FAIL w8_ready got %b want 1", s8_ready); end
    @(posedge clk); #1;
    s8_valid = 1'b0; s8_sof = 1'b0; s8_eof = 1'b0;
  endtask

  task automatic beat64(input logic [63:0] d, input logic [7:0] k, input logic sof, input logic eof);
    s64_valid = 1'b1; s64_data = d; s64_keep = k; s64_sof = sof; s64_eof = eof;
    #1;
    checks++; if (s64_ready !== 1'b1) begin errors++; $display("FAIL w64_ready got %b want 1", s64_ready); end
    @(posedge clk); #1;
    s64_valid = 1'b0; s64_sof = 1'b0; s64_eof = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_valid = 0; s_data = 0; s_keep = 0; s_sof = 0; s_eof = 0; s_mode = 0; m_ready = 1;
    s8_valid = 0; s8_data = 0; s8_keep = 0; s8_sof = 0; s8_eof = 0;
    s64_valid = 0; s64_data = 0; s64_keep = 0; s64_sof = 0; s64_eof = 0;
    #12;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready got %b want 1", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got %b want 0", m_valid); end
    checks++; if (m_crc !== 32'h0) begin errors++; $display("FAIL rst_m_crc got %h want 00000000", m_crc); end
    checks++; if ({m_ok, m_err, busy} !== 3'b000) begin errors++; $display("FAIL rst_ok_err_busy got %b want 000", {m_ok, m_err, busy}); end
    @(negedge clk); rst = 1'b0;
    idle();
  endtask

  task automatic test_generate();
    beat(32'h34333231, 4'hF, 1, 0, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gen_busy got %b want 1", busy); end
    beat(32'h38373635, 4'hF, 0, 0, 0);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL gen_early_valid got %b want 0", m_valid); end
    beat(32'h00000039, 4'h1, 0, 1, 0);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL gen_valid got %b want 1", m_valid); end
    checks++; if (m_crc !== 32'hCBF43926) begin errors++; $display("FAIL gen_crc got %h want cbf43926", m_crc); end
    checks++; if ({m_ok, m_err, busy} !== 3'b000) begin errors++; $display("FAIL gen_ok_err_busy got %b want 000", {m_ok, m_err, busy}); end
    idle();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL gen_drain got %b want 0", m_valid); end
  endtask

  task automatic test_check();
    beat(32'h34333231, 4'hF, 1, 0, 1);
    beat(32'h38373635, 4'hF, 0, 0, 0);
    beat(32'hF4392639, 4'hF, 0, 0, 0);
    beat(32'h000000CB, 4'h1, 0, 1, 0);
    checks++; if (m_ok !== 1'b1) begin errors++; $display("FAIL chk_ok got %b want 1", m_ok); end
    checks++; if (m_crc !== 32'h2144DF1C) begin errors++; $display("FAIL chk_crc got %h want 2144df1c", m_crc); end
    checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL chk_err got %b want 0", m_err); end
    beat(32'h34333230, 4'hF, 1, 0, 1);
    beat(32'h38373635, 4'hF, 0, 0, 0);
    beat(32'hF4392639, 4'hF, 0, 0, 0);
    beat(32'h000000CB, 4'h1, 0, 1, 0);
    checks++; if ({m_valid, m_ok} !== 2'b10) begin errors++; $display("FAIL chk_flip valid/ok got %b want 10", {m_valid, m_ok}); end
    idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      beat(32'h00000061, 4'h1, 1, 1, 0);
      checks++; if ({m_valid, busy} !== 2'b10) begin errors++; $display("FAIL b2b_valid_busy[%0d] got %b want 10", i, {m_valid, busy}); end
      checks++; if (m_crc !== 32'hE8B7BE43) begin errors++; $display("FAIL b2b_crc[%0d] got %h want e8b7be43", i, m_crc); end
    end
    idle();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", m_valid); end
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    beat(32'h00000061, 4'h1, 1, 1, 0);
    beat(32'h34333231, 4'hF, 1, 0, 0);
    beat(32'h38373635, 4'hF, 0, 0, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_flow busy got %b want 1", busy); end
    s_valid = 1; s_data = 32'h39; s_keep = 4'h1; s_eof = 1;
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_stall s_ready got %b want 0", s_ready); end
    @(posedge clk); #1;
    checks++; if ({m_valid, busy} !== 2'b11) begin errors++; $display("FAIL bp_hold valid/busy got %b want 11", {m_valid, busy}); end
    checks++; if (m_crc !== 32'hE8B7BE43) begin errors++; $display("FAIL bp_hold_crc got %h want e8b7be43", m_crc); end
    m_ready = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_release s_ready got %b want 1", s_ready); end
    @(posedge clk); #1;
    s_valid = 0; s_eof = 0;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid got %b want 1", m_valid); end
    checks++; if (m_crc !== 32'hCBF43926) begin errors++; $display("FAIL bp_second_crc got %h want cbf43926", m_crc); end
    idle();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", m_valid); end
  endtask

  task automatic test_errors();
    beat(32'h11111111, 4'hF, 1, 0, 0);
    beat(32'h22222222, 4'hF, 0, 0, 0);
    beat(32'h34333231, 4'hF, 1, 0, 0);
    checks++; if ({m_valid, busy} !== 2'b01) begin errors++; $display("FAIL err_abort valid/busy got %b want 01", {m_valid, busy}); end
    beat(32'h38373635, 4'hF, 0, 0, 0);
    beat(32'h00000039, 4'h1, 0, 1, 0);
    checks++; if (m_crc !== 32'hCBF43926) begin errors++; $display("FAIL err_restart_crc got %h want cbf43926", m_crc); end
    checks++; if (m_err !== 1'b1) begin errors++; $display("FAIL err_restart_err got %b want 1", m_err); end
    beat(32'h00000061, 4'h1, 1, 1, 0);
    checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL err_cleared got %b want 0", m_err); end
    beat(32'h34333231, 4'hF, 1, 0, 0);
    beat(32'h00390039, 4'h5, 0, 1, 0);
    checks++; if ({m_valid, m_err} !== 2'b11) begin errors++; $display("FAIL err_keep0101 valid/err got %b want 11", {m_valid, m_err}); end
    beat(32'h55555555, 4'hF, 0, 0, 0);
    checks++; if ({m_valid, busy} !== 2'b00) begin errors++; $display("FAIL err_drop valid/busy got %b want 00", {m_valid, busy}); end
    beat(32'h00000061, 4'h1, 1, 1, 0);
    checks++; if ({m_err, m_crc} !== {1'b1, 32'hE8B7BE43}) begin errors++; $display("FAIL err_drop_next err/crc got %b/%h want 1/e8b7be43", m_err, m_crc); end
    beat(32'h34333231, 4'h3, 1, 0, 0);
    beat(32'h00000039, 4'h1, 0, 1, 0);
    checks++; if (m_err !== 1'b1) begin errors++; $display("FAIL err_partial_keep got %b want 1", m_err); end
    idle();
  endtask

  task automatic test_async_reset();
    m_ready = 1'b0;
    beat(32'h00000061, 4'h1, 1, 1, 0);
    beat(32'h34333231, 4'hF, 1, 0, 0);
    #2 rst = 1'b1;
    #1;
    checks++; if ({m_valid, busy, m_ok, m_err} !== 4'b0000) begin errors++; $display("FAIL arst_flags got %b want 0000", {m_valid, busy, m_ok, m_err}); end
    checks++; if (m_crc !== 32'h0) begin errors++; $display("FAIL arst_crc got %h want 00000000", m_crc); end
    #1 rst = 1'b0;
    m_ready = 1'b1;
    idle();
    beat(32'h34333231, 4'hF, 1, 0, 0);
    beat(32'h38373635, 4'hF, 0, 0, 0);
    beat(32'h00000039, 4'h1, 0, 1, 0);
    checks++; if ({m_valid, m_err, m_crc} !== {2'b10, 32'hCBF43926}) begin errors++; $display("FAIL arst_after got %b%b/%h want 10/cbf43926", m_valid, m_err, m_crc); end
    idle();
  endtask

  task automatic test_width8();
    logic [71:0] msg;
    msg = "123456789";
    for (int i = 0; i < 9; i++) begin
      beat8(msg[8*(8-i) +: 8], i == 0, i == 8);
      if (i == 7) begin
        checks++; if ({m8_valid, busy8} !== 2'b01) begin errors++; $display("FAIL w8_mid valid/busy got %b want 01", {m8_valid, busy8}); end
      end
    end
    checks++; if ({m8_valid, m8_err, m8_crc} !== {2'b10, 32'hCBF43926}) begin errors++; $display("FAIL w8_result got %b%b/%h want 10/cbf43926", m8_valid, m8_err, m8_crc); end
  endtask

  task automatic test_width64();
    beat64(64'h3837363534333231, 8'hFF, 1, 0);
    beat64(64'h0000000000000039, 8'h01, 0, 1);
    checks++; if ({m64_valid, m64_err, m64_crc} !== {2'b10, 32'hCBF43926}) begin errors++; $display("FAIL w64_result got %b%b/%h want 10/cbf43926", m64_valid, m64_err, m64_crc); end
  endtask

  initial begin
    test_reset();
    test_generate();
    test_check();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_async_reset();
    test_width8();
    test_width64();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
